// File: rtl/usr_h2c0_unpack.sv
// H2C channel 0 receive sink: takes the 128-bit AXI-Stream from the SGDMA core,
// checks framing and byte enables, and buffers beats in a FWFT FIFO. The user side
// sees a valid/ready stream with start/stop markers, frame/error counters and a
// per-frame interrupt request.
module usr_h2c0_unpack #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned KEEP_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_FRAME_BEATS = 4096
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst_n,
  input  logic                  usr_h2c0w_run_i,
  input  logic                  m0_axis_h2c_rst_i,
  output logic                  m0_axis_h2c_tready_o,
  input  logic [DATA_WIDTH-1:0] m0_axis_h2c_tdata_i,
  input  logic [KEEP_WIDTH-1:0] m0_axis_h2c_tkeep_i,
  input  logic [KEEP_WIDTH-1:0] m0_axis_h2c_tuser_i,
  input  logic                  m0_axis_h2c_tlast_i,
  input  logic                  m0_axis_h2c_tvalid_i,
  output logic [DATA_WIDTH-1:0] usr_data_o,
  output logic [KEEP_WIDTH-1:0] usr_keep_o,
  output logic                  usr_valid_o,
  input  logic                  usr_ready_i,
  output logic                  usr_start_o,
  output logic                  usr_stop_o,
  output logic [31:0]           usr_frm_cnt_o,
  output logic [31:0]           usr_h2c0err_num_o,
  output logic                  usr_h2c0irq_req_o,
  input  logic                  usr_h2c0irq_ack_i
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BEAT_W  = $clog2(MAX_FRAME_BEATS + 1);
  localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INFRM = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  // frame tracking
  state_t             state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_inc;

  // counters and interrupt
  logic [31:0]        frm_cnt;
  logic [31:0]        err_cnt;
  logic [32:0]        err_sum;
  logic [1:0]         err_inc;
  logic               irq_req;

  // handshake and classification
  logic               flush;
  logic               not_full;
  logic               tready;
  logic               accept;
  logic               fifo_valid;
  logic               show;
  logic               pop;
  logic               push;
  logic               tag_first;
  logic               tag_last;
  logic               ovr_err;
  logic               keep_err;
  logic               keep_full;
  logic               keep_contig;
  logic [KEEP_WIDTH-1:0] keep_plus;

  logic [ENTRY_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [KEEP_WIDTH-1:0] head_keep;
  logic                  head_first;
  logic                  head_last;

  // tuser carries nothing this block needs
  logic unused_tuser;
  assign unused_tuser = ^m0_axis_h2c_tuser_i;

  // intake handshake; reset and flush both hold the stream off
  assign flush      = m0_axis_h2c_rst_i;
  assign not_full   = (count < CNT_W'(FIFO_DEPTH));
  assign tready     = usr_rst_n & usr_h2c0w_run_i & ~flush & not_full;
  assign accept     = m0_axis_h2c_tvalid_i & tready;
  assign fifo_valid = (count != '0);
  assign show       = usr_rst_n & fifo_valid;
  assign pop        = show & usr_ready_i & ~flush;
  assign beat_inc   = beat_cnt + BEAT_W'(1);

  // classify the accepted beat: push or discard, and its first/last tags
  always_comb begin
    push      = 1'b0;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    ovr_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          push      = 1'b1;
          tag_first = 1'b1;
          tag_last  = m0_axis_h2c_tlast_i;
        end
      end
      S_INFRM: begin
        if (accept) begin
          push = 1'b1;
          if (m0_axis_h2c_tlast_i) begin
            tag_last = 1'b1;
          end else if (beat_inc == BEAT_W'(MAX_FRAME_BEATS)) begin
            tag_last = 1'b1;
            ovr_err  = 1'b1;
          end
        end
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // byte-enable check on pushed beats: full for body beats, contiguous from bit 0 for the last
  assign keep_plus   = m0_axis_h2c_tkeep_i + KEEP_WIDTH'(1);
  assign keep_full   = &m0_axis_h2c_tkeep_i;
  assign keep_contig = (m0_axis_h2c_tkeep_i != '0) && ((m0_axis_h2c_tkeep_i & keep_plus) == '0);
  assign keep_err    = push & (tag_last ? ~keep_contig : ~keep_full);
  assign err_inc     = {1'b0, ovr_err} + {1'b0, keep_err};
  assign err_sum     = {1'b0, err_cnt} + 33'(err_inc);

  // frame state machine: IDLE -> INFRM on a multi-beat frame, DROP after overrun
  always_ff @(posedge usr_clk) begin
    if (!usr_rst_n || flush) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !m0_axis_h2c_tlast_i) begin
            state    <= S_INFRM;
            beat_cnt <= BEAT_W'(1);
          end
        end
        S_INFRM: begin
          if (accept) begin
            beat_cnt <= beat_inc;
            if (m0_axis_h2c_tlast_i) begin
              state <= S_IDLE;
            end else if (beat_inc == BEAT_W'(MAX_FRAME_BEATS)) begin
              state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (accept && m0_axis_h2c_tlast_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge usr_clk) begin
    if (!usr_rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset
  always_ff @(posedge usr_clk) begin
    if (push) begin
      mem[wr_ptr] <= {m0_axis_h2c_tdata_i, m0_axis_h2c_tkeep_i, tag_first, tag_last};
    end
  end

  assign head       = mem[rd_ptr];
  assign head_data  = head[ENTRY_W-1 -: DATA_WIDTH];
  assign head_keep  = head[2 +: KEEP_WIDTH];
  assign head_first = head[1];
  assign head_last  = head[0];

  // saturating frame and error counters; flush leaves them alone
  always_ff @(posedge usr_clk) begin
    if (!usr_rst_n) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pop && head_last && (frm_cnt != 32'hFFFF_FFFF)) begin
        frm_cnt <= frm_cnt + 32'd1;
      end
      err_cnt <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end
  end

  // frame-done interrupt: set on a last-beat pop, set beats a same-cycle ack
  always_ff @(posedge usr_clk) begin
    if (!usr_rst_n || flush) begin
      irq_req <= 1'b0;
    end else if (pop && head_last) begin
      irq_req <= 1'b1;
    end else if (usr_h2c0irq_ack_i) begin
      irq_req <= 1'b0;
    end
  end

  // user-facing outputs read zero while in reset or empty
  assign m0_axis_h2c_tready_o = tready;
  assign usr_valid_o          = show;
  assign usr_data_o           = show ? head_data : '0;
  assign usr_keep_o           = show ? head_keep : '0;
  assign usr_start_o          = show & head_first;
  assign usr_stop_o           = show & head_last;
  assign usr_frm_cnt_o        = usr_rst_n ? frm_cnt : '0;
  assign usr_h2c0err_num_o    = usr_rst_n ? err_cnt : '0;
  assign usr_h2c0irq_req_o    = usr_rst_n & irq_req;

endmodule

// File: tb/tb_usr_h2c0_unpack.sv
// Directed bench for usr_h2c0_unpack: a default instance plus a short-frame-limit
// instance (MAX_FRAME_BEATS=8) share the same stimulus; popped beats are logged per instance.
module tb_usr_h2c0_unpack;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         start;
    logic         stop;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         run;
  logic         flush;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic [15:0]  tuser;
  logic         tlast;
  logic         tvalid;
  logic         ready;
  logic         ack;

  logic         tready;
  logic [127:0] data;
  logic [15:0]  keep;
  logic         valid;
  logic         start;
  logic         stop;
  logic [31:0]  frm;
  logic [31:0]  err;
  logic         irq;

  logic         o_tready;
  logic [127:0] o_data;
  logic [15:0]  o_keep;
  logic         o_valid;
  logic         o_start;
  logic         o_stop;
  logic [31:0]  o_frm;
  logic [31:0]  o_err;
  logic         o_irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  beat_t q[$];
  beat_t qo[$];

  usr_h2c0_unpack dut (
    .usr_clk(clk), .usr_rst_n(rst_n), .usr_h2c0w_run_i(run), .m0_axis_h2c_rst_i(flush),
    .m0_axis_h2c_tready_o(tready), .m0_axis_h2c_tdata_i(tdata), .m0_axis_h2c_tkeep_i(tkeep),
    .m0_axis_h2c_tuser_i(tuser), .m0_axis_h2c_tlast_i(tlast), .m0_axis_h2c_tvalid_i(tvalid),
    .usr_data_o(data), .usr_keep_o(keep), .usr_valid_o(valid), .usr_ready_i(ready),
    .usr_start_o(start), .usr_stop_o(stop), .usr_frm_cnt_o(frm), .usr_h2c0err_num_o(err),
    .usr_h2c0irq_req_o(irq), .usr_h2c0irq_ack_i(ack)
  );

  usr_h2c0_unpack #(.MAX_FRAME_BEATS(8)) dut_ovr (
    .usr_clk(clk), .usr_rst_n(rst_n), .usr_h2c0w_run_i(run), .m0_axis_h2c_rst_i(flush),
    .m0_axis_h2c_tready_o(o_tready), .m0_axis_h2c_tdata_i(tdata), .m0_axis_h2c_tkeep_i(tkeep),
    .m0_axis_h2c_tuser_i(tuser), .m0_axis_h2c_tlast_i(tlast), .m0_axis_h2c_tvalid_i(tvalid),
    .usr_data_o(o_data), .usr_keep_o(o_keep), .usr_valid_o(o_valid), .usr_ready_i(ready),
    .usr_start_o(o_start), .usr_stop_o(o_stop), .usr_frm_cnt_o(o_frm), .usr_h2c0err_num_o(o_err),
    .usr_h2c0irq_req_o(o_irq), .usr_h2c0irq_ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // log every beat each instance hands to the user side
  always @(negedge clk) begin
    if (rst_n && !flush && ready) begin
      if (valid)   q.push_back('{data: data, keep: keep, start: start, stop: stop});
      if (o_valid) qo.push_back('{data: o_data, keep: o_keep, start: o_start, stop: o_stop});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; run = 1'b1; flush = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    ready = 1'b0; ack = 1'b0; tdata = '0; tkeep = '0; tuser = '0;
    wait_cycles(2);
    rst_n = 1'b1;
    q.delete();
    qo.delete();
  endtask

  // offer one beat and hold it until accepted (bounded)
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n;
    n = 0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    @(negedge clk);
    while (!tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!tready) chk("send_tready", 128'(tready), 128'd1);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    int acc;
    int bad;
    int t0;

    // reset: every output reads zero while reset is held, even with run=1
    rst_n = 1'b0; run = 1'b1; flush = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    ready = 1'b0; ack = 1'b0; tdata = '0; tkeep = '0; tuser = '0;
    wait_cycles(2);
    @(negedge clk);
    chk("rst_tready", 128'(tready), 128'd0);
    chk("rst_valid",  128'(valid),  128'd0);
    chk("rst_frm",    128'(frm),    128'd0);
    chk("rst_err",    128'(err),    128'd0);
    chk("rst_irq",    128'(irq),    128'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 128'(tready), 128'd1);
    tick();

    // 4-beat frame, short last keep
    reset_dut();
    ready = 1'b1;
    send(128'hA0, 16'hFFFF, 1'b0);
    send(128'hA1, 16'hFFFF, 1'b0);
    send(128'hA2, 16'hFFFF, 1'b0);
    send(128'hA3, 16'h00FF, 1'b1);
    wait_cycles(3);
    chk("f4_count", 128'(q.size()), 128'd4);
    if (q.size() == 4) begin
      chk("f4_start0", 128'({q[0].start, q[1].start, q[2].start, q[3].start}), 128'b1000);
      chk("f4_stop",   128'({q[0].stop,  q[1].stop,  q[2].stop,  q[3].stop}),  128'b0001);
      chk("f4_keep3",  128'(q[3].keep), 128'h00FF);
      chk("f4_data3",  q[3].data, 128'hA3);
    end
    chk("f4_frm", 128'(frm), 128'd1);
    chk("f4_err", 128'(err), 128'd0);
    chk("f4_irq", 128'(irq), 128'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    @(negedge clk);
    chk("f4_irq_acked", 128'(irq), 128'd0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    @(negedge clk);
    chk("spurious_ack_irq", 128'(irq), 128'd0);
    tick();
    // ack held across a last-beat pop: set wins, then ack clears a cycle later
    ack = 1'b1;
    send(128'hB0, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("irq_set_prio", 128'(irq), 128'd1);
    @(negedge clk);
    chk("irq_ack_after", 128'(irq), 128'd0);
    chk("prio_frm", 128'(frm), 128'd2);
    tick();
    ack = 1'b0;

    // fill the FIFO with the user side stalled
    reset_dut();
    acc = 0;
    tvalid = 1'b1; tkeep = 16'hFFFF; tlast = 1'b0; tdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tready) acc++;
      tick();
      tdata = 128'(acc);
    end
    chk("full_accepts", 128'(acc), 128'd16);
    @(negedge clk);
    chk("full_tready", 128'(tready), 128'd0);
    chk("full_valid",  128'(valid),  128'd1);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    chk("full_tready_after_pop", 128'(tready), 128'd1);
    tick();
    tvalid = 1'b0;
    ready = 1'b1;
    wait_cycles(20);
    chk("full_drain_count", 128'(q.size()), 128'd17);
    bad = 0;
    foreach (q[i]) if (q[i].data != 128'(i) || q[i].start != (i == 0) || q[i].stop) bad++;
    chk("full_order", 128'(bad), 128'd0);

    // keep violations on a body beat and on the last beat
    reset_dut();
    ready = 1'b1;
    send(128'hC0, 16'hFFFF, 1'b0);
    send(128'hC1, 16'h7FFF, 1'b0);
    send(128'hC2, 16'h00F0, 1'b1);
    wait_cycles(3);
    chk("keep_err", 128'(err), 128'd2);
    chk("keep_frm", 128'(frm), 128'd1);
    chk("keep_count", 128'(q.size()), 128'd3);
    if (q.size() == 3) begin
      chk("keep_k1", 128'(q[1].keep), 128'h7FFF);
      chk("keep_k2", 128'(q[2].keep), 128'h00F0);
      chk("keep_d1", q[1].data, 128'hC1);
      chk("keep_stop2", 128'(q[2].stop), 128'd1);
    end

    // overrun on the 8-beat-limit instance: 12 beats, tlast on the 12th
    reset_dut();
    ready = 1'b1;
    for (int i = 0; i < 12; i++) send(128'(i), 16'hFFFF, i == 11);
    wait_cycles(3);
    chk("ovr_count", 128'(qo.size()), 128'd8);
    bad = 0;
    foreach (qo[i]) if (qo[i].data != 128'(i) || qo[i].start != (i == 0) || qo[i].stop != (i == 7)) bad++;
    chk("ovr_order", 128'(bad), 128'd0);
    chk("ovr_err", 128'(o_err), 128'd1);
    chk("ovr_frm", 128'(o_frm), 128'd1);
    chk("ovr_ref_count", 128'(q.size()), 128'd12);
    chk("ovr_ref_err", 128'(err), 128'd0);
    send(128'h55, 16'hFFFF, 1'b1);
    wait_cycles(3);
    chk("ovr_next_count", 128'(qo.size()), 128'd9);
    if (qo.size() == 9) begin
      chk("ovr_next_start", 128'({qo[8].start, qo[8].stop}), 128'b11);
      chk("ovr_next_data", qo[8].data, 128'h55);
    end

    // flush with five beats buffered mid-frame
    reset_dut();
    ready = 1'b1;
    send(128'hD0, 16'hFFFF, 1'b1);
    wait_cycles(3);
    chk("fl_irq_before", 128'(irq), 128'd1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send(128'hE0 + 128'(i), 16'hFFFF, 1'b0);
    @(negedge clk);
    chk("fl_valid_before", 128'(valid), 128'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_tready", 128'(tready), 128'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", 128'(valid), 128'd0);
    chk("fl_irq",   128'(irq),   128'd0);
    chk("fl_frm",   128'(frm),   128'd1);
    tick();
    q.delete();
    ready = 1'b1;
    send(128'hF0, 16'hFFFF, 1'b1);
    wait_cycles(3);
    chk("fl_next_count", 128'(q.size()), 128'd1);
    if (q.size() == 1) chk("fl_next_tags", 128'({q[0].start, q[0].stop}), 128'b11);
    chk("fl_next_frm", 128'(frm), 128'd2);

    // 100-beat streaming frame with both sides always ready
    reset_dut();
    ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 100; i++) send(128'h1000 + 128'(i), 16'hFFFF, i == 99);
    chk("stream_cycles", 128'(cyc - t0), 128'd100);
    wait_cycles(3);
    chk("stream_count", 128'(q.size()), 128'd100);
    bad = 0;
    foreach (q[i]) if (q[i].data != 128'h1000 + 128'(i) || q[i].start != (i == 0) || q[i].stop != (i == 99)) bad++;
    chk("stream_order", 128'(bad), 128'd0);
    chk("stream_frm", 128'(frm), 128'd1);
    chk("stream_err", 128'(err), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_h2c0_unpack.md
Name: usr_h2c0_unpack

Overview:
- Host-to-card receive sink for DMA channel 0. It consumes the 128-bit AXI-Stream H2C stream from the SGDMA core.
- Checks framing and keep, buffers beats in a first-word-fall-through (FWFT) FIFO, and presents them to user logic as a valid/ready stream with start/stop frame markers.
- Counts frames and errors, and raises the H2C user interrupt per completed frame.
- It is the receive-side counterpart of the C2H packer that turns the pcie_data/valid/start/stop interface into AXI-Stream.

Parameters:
- DATA_WIDTH, 128, stream data width in bits.
- KEEP_WIDTH, 16, byte-enable width (DATA_WIDTH/8).
- FIFO_DEPTH, 16, beat buffer depth; power of 2, minimum 4.
- MAX_FRAME_BEATS, 4096, maximum beats per frame before overrun is declared.

Ports:
- usr_clk  in  1  clock; all logic on rising edge.
- usr_rst_n  in  1  reset, synchronous, active-low.
- usr_h2c0w_run_i  in  1  enable; 0 stalls intake.
- m0_axis_h2c_rst_i  in  1  channel flush, synchronous, active-high.
- m0_axis_h2c_tready_o  out  1  AXIS ready.
- m0_axis_h2c_tdata_i  in  DATA_WIDTH  AXIS data.
- m0_axis_h2c_tkeep_i  in  KEEP_WIDTH  AXIS byte enables.
- m0_axis_h2c_tuser_i  in  KEEP_WIDTH  ignored.
- m0_axis_h2c_tlast_i  in  1  end of frame.
- m0_axis_h2c_tvalid_i  in  1  AXIS valid.
- usr_data_o  out  DATA_WIDTH  FIFO head data.
- usr_keep_o  out  KEEP_WIDTH  FIFO head keep.
- usr_valid_o  out  1  FIFO non-empty.
- usr_ready_i  in  1  user pop.
- usr_start_o  out  1  head beat is first of frame.
- usr_stop_o  out  1  head beat is last of frame.
- usr_frm_cnt_o  out  32  completed frames popped.
- usr_h2c0err_num_o  out  32  error count.
- usr_h2c0irq_req_o  out  1  frame-done interrupt request.
- usr_h2c0irq_ack_i  in  1  interrupt acknowledge.

Behaviour:
Reset:
- usr_rst_n=0 at a clock edge empties the FIFO, sets state to IDLE, and clears all counters and irq_req.
- All outputs read 0 during reset, including tready and usr_valid_o.
- The FIFO storage contents themselves are don't-care.

Intake:
- tready = run & ~flush & (count < FIFO_DEPTH).
- A beat is accepted when tvalid & tready.
- No pass-through when full.

FIFO:
- Entry is {data, keep, first, last}.
- An accepted beat appears on the usr_* outputs on the next cycle (latency 1).
- A pop occurs on usr_valid_o & usr_ready_i.
- Simultaneous push and pop leave count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Frame state machine (IDLE, INFRM, DROP):
- IDLE: an accepted beat is tagged first=1.
  - With tlast, last=1 and the state stays IDLE.
  - Without tlast, the beat counter is set to 1 and the state moves to INFRM.
- INFRM: each accepted beat increments the beat counter.
  - tlast tags last=1 and returns to IDLE.
  - If the beat counter reaches MAX_FRAME_BEATS without tlast, that beat is forced last=1, error +1, and the state moves to DROP.
- DROP: tready still follows the intake rule, but accepted beats are discarded (not pushed).
  - tlast returns to IDLE.

Keep check:
- Non-last beats require all-ones keep.
- Last beats require nonzero keep, contiguous from bit 0.
- A violation adds error +1 per beat; the beat is still forwarded unmodified.

Error accounting:
- The overrun and keep errors are separate sources; if both occur on the same beat, error +2.

Counters:
- usr_frm_cnt_o increments when a last=1 beat is popped.
- Both counters saturate at 0xFFFFFFFF.

Interrupt:
- irq_req is set the cycle after a last=1 pop.
- It is cleared by ack; set has priority over a same-cycle ack.
- With irq_req=0, a spurious ack is ignored.

run=0 mid-frame:
- tready=0, state and beat counter are held, and output pop continues.

Flush (m0_axis_h2c_rst_i=1):
- Empties the FIFO, sets state to IDLE, clears the beat counter and irq_req, and forces tready=0.
- Counters are kept.
- Flush has priority over push and pop in the same cycle.

Test Plan:
- run=1, usr_ready=1, 4-beat frame, full keep, last keep=0x00FF -> usr_start on beat 0 only, usr_stop on beat 3 with keep 0x00FF, frm_cnt=1, irq_req=1 until ack, err=0.
- usr_ready=0, 20 beats offered without tlast, FIFO_DEPTH=16 -> tready drops after 16 accepts, count=16; usr_ready=1 for 1 cycle, then tready=1 on the next cycle.
- Last beat keep=0x00F0, and a mid beat keep=0x7FFF -> err=2, all beats delivered unchanged, frm_cnt=1.
- MAX_FRAME_BEATS=8, 12 beats then tlast -> 8 beats delivered with stop on the 8th, beats 9..12 dropped, err=1, frm_cnt=1, next frame starts with start=1.
- m0_axis_h2c_rst pulse with 5 beats buffered mid-frame -> usr_valid=0 next cycle, irq_req=0, next accepted beat tagged start=1, frm_cnt unchanged.
- Continuous push and pop with tvalid=usr_ready=1 for 100 beats of one frame -> count stays at 1, one beat per cycle, data order preserved, across at least 6 pointer wraps.
